spram_burst_reader: RTL and testbench

- Initiator-side controller for a 2048x40 single-port RAM; reads bursts from it.
- Accepts a burst command (start address, length) and drives the RAM's address/wren/data pins.
- Captures the RAM's 1-cycle-latency read data and streams it downstream with valid/ready backpressure.
- Sits between layer-control FSMs and weight/activation SPRAM banks; the RAM instance is external.

---
 rtl/spram_burst_reader_pkg.sv | 15 +
 rtl/spram_burst_fifo.sv | 60 ++++++
 rtl/spram_burst_reader.sv | 166 ++++++++++++++++
 tb/tb_spram_burst_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_burst_reader_pkg.sv
// Shared types and default widths for the SPRAM burst reader.
// Also used by spram_burst_reader.sv (optional feature macro: SPRAM_BURST_READER_LAST_EN).
package spram_burst_reader_pkg;

    localparam int AWIDTH_DEFAULT    = 11;
    localparam int DWIDTH_DEFAULT    = 40;
    localparam int NUM_WORDS_DEFAULT = 2048;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/spram_burst_fifo.sv
// Small synchronous FIFO that buffers captured RAM words ahead of the downstream port.
// A push and a pop in the same cycle are both honoured, even when the FIFO is full.
module spram_burst_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spram_burst_reader.sv
// Burst read controller for an external single-port RAM with 1-cycle read latency.
// Optional macro SPRAM_BURST_READER_LAST_EN adds dout_last, flagging the final word of each burst.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// BURST | issuing reads while FIFO plus in-flight word leaves room
// DRAIN | all reads issued; waiting for in-flight word and FIFO to empty
module spram_burst_reader
    import spram_burst_reader_pkg::*;
#(
    parameter int AWIDTH     = AWIDTH_DEFAULT,
    parameter int NUM_WORDS  = NUM_WORDS_DEFAULT,
    parameter int DWIDTH     = DWIDTH_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH:0]   cmd_len,
    output logic [AWIDTH-1:0] ram_address,
    output logic              ram_wren,
    output logic [DWIDTH-1:0] ram_data,
    input  logic [DWIDTH-1:0] ram_out,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DWIDTH-1:0] dout_data,
    output logic              busy,
    output logic              done
`ifdef SPRAM_BURST_READER_LAST_EN
    ,
    output logic              dout_last
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
`ifdef SPRAM_BURST_READER_LAST_EN
    localparam int FW = DWIDTH + 1;
`else
    localparam int FW = DWIDTH;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] ptr;
    logic [AWIDTH:0]   rem;
    logic              inflight;
    logic              issue;
    logic              pop;
    logic              done_nxt;
    logic              last_issue;
    logic              credit_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W:0]    credit_limit;
    logic [FW-1:0]     fifo_wdata;
    logic [FW-1:0]     fifo_rdata;

    // A word popped this cycle frees a slot for a read issued this cycle.
    assign occupancy    = {1'b0, fifo_count} + (CNT_W+1)'(inflight);
    assign credit_limit = (CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(pop);
    assign credit_ok    = !(fifo_full && !pop) && (occupancy < credit_limit);
    assign last_issue   = (rem == (AWIDTH+1)'(1));

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        cmd_ready = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = BURST;
                    end
                end
            end
            BURST: begin
                issue = credit_ok;
                if (credit_ok && last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && fifo_empty) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            rem      <= '0;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            inflight <= issue;
            done     <= done_nxt;
            if (cmd_ready && cmd_valid) begin
                ptr <= cmd_addr;
                rem <= cmd_len;
            end else if (issue) begin
                ptr <= (ptr == AWIDTH'(NUM_WORDS - 1)) ? '0 : ptr + AWIDTH'(1);
                rem <= rem - (AWIDTH+1)'(1);
            end
        end
    end

`ifdef SPRAM_BURST_READER_LAST_EN
    logic inflight_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_last <= 1'b0;
        end else begin
            inflight_last <= issue && last_issue;
        end
    end

    assign fifo_wdata = {inflight_last, ram_out};
    assign dout_last  = fifo_rdata[DWIDTH];
`else
    assign fifo_wdata = ram_out;
`endif

    spram_burst_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pop         = dout_valid && dout_ready;
    assign dout_valid  = !fifo_empty;
    assign dout_data   = fifo_rdata[DWIDTH-1:0];
    assign ram_address = ptr;
    assign ram_wren    = 1'b0;
    assign ram_data    = '0;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_spram_burst_reader.sv
// Directed bench for spram_burst_reader against a behavioural 1-cycle-latency RAM holding RAM[i]=i.
// Inputs change and outputs are sampled on the falling edge.
module tb_spram_burst_reader;
    localparam int AW = 11;
    localparam int DW = 40;
    localparam int NW = 2048;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic [AW-1:0] ram_address;
    logic          ram_wren;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_out;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] dout_data;
    logic          busy;
    logic          done;
`ifdef SPRAM_BURST_READER_LAST_EN
    logic          dout_last;
`endif

    int total = 0;
    int bad = 0;
    int wr_bad = 0;

    logic [DW-1:0] ram_mem [NW];

    spram_burst_reader dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .ram_address (ram_address),
        .ram_wren    (ram_wren),
        .ram_data    (ram_data),
        .ram_out     (ram_out),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_data   (dout_data),
        .busy        (busy),
        .done        (done)
`ifdef SPRAM_BURST_READER_LAST_EN
        ,
        .dout_last   (dout_last)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_out <= ram_mem[ram_address];

    always @(negedge clk) begin
        if (!reset && (ram_wren !== 1'b0 || ram_data !== '0)) wr_bad++;
    end

    // Returns at the falling edge right after the accepting rising edge.
    task automatic issue_cmd(input int addr, input int len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = AW'(addr);
        cmd_len   = (AW+1)'(len);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        total++;
        if ({dout_valid, busy, done} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got valid/busy/done=%b want 000", {dout_valid, busy, done});
        end
        total++;
        if (ram_address !== '0 || dout_data !== '0) begin
            bad++; $display("FAIL reset_buses: got addr=%0d data=%0d want 0 0", ram_address, dout_data);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: got cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_basic;
        int nw = 0, first_k = -1, done_cnt = 0, done_k = -1;
        logic busy_at_done = 1'bx, busy_k7 = 1'bx;
        logic [DW-1:0] w [4];
        int wk [4];
        dout_ready = 1'b1;
        issue_cmd(5, 4);
        for (int k = 1; k <= 14; k++) begin
            if (dout_valid) begin
                if (first_k < 0) first_k = k;
                if (nw < 4) begin w[nw] = dout_data; wk[nw] = k; end
                nw++;
            end
            if (done) begin done_cnt++; done_k = k; busy_at_done = busy; end
            if (k == 7) busy_k7 = busy;
            @(negedge clk);
        end
        total++;
        if (first_k !== 3) begin
            bad++; $display("FAIL basic_latency: got first valid at %0d want 3", first_k);
        end
        total++;
        if (nw !== 4) begin
            bad++; $display("FAIL basic_count: got %0d words want 4", nw);
        end
        for (int i = 0; i < 4 && i < nw; i++) begin
            total++;
            if (w[i] !== DW'(5 + i) || wk[i] !== 3 + i) begin
                bad++; $display("FAIL basic_word[%0d]: got %0d at %0d want %0d at %0d", i, w[i], wk[i], 5 + i, 3 + i);
            end
        end
        total++;
        if (done_cnt !== 1 || done_k !== 8) begin
            bad++; $display("FAIL basic_done: got %0d pulses at %0d want 1 at 8", done_cnt, done_k);
        end
        total++;
        if (busy_at_done !== 1'b0 || busy_k7 !== 1'b1) begin
            bad++; $display("FAIL basic_busy: got busy@done=%b busy@7=%b want 0 1", busy_at_done, busy_k7);
        end
    endtask

    task automatic test_backpressure;
        int nw = 0, done_cnt = 0;
        logic [DW-1:0] w [8];
        dout_ready = 1'b1;
        issue_cmd(0, 8);
        for (int k = 1; k <= 40; k++) begin
            dout_ready = (k < 4 || k >= 14);
            if (k >= 5 && k <= 13) begin
                total++;
                if (ram_address !== AW'(3)) begin
                    bad++; $display("FAIL bp_addr_hold k=%0d: got %0d want 3", k, ram_address);
                end
                total++;
                if (dout_valid !== 1'b1 || dout_data !== DW'(1)) begin
                    bad++; $display("FAIL bp_head_hold k=%0d: got valid=%b data=%0d want 1 1", k, dout_valid, dout_data);
                end
            end
            if (dout_valid && dout_ready) begin
                if (nw < 8) w[nw] = dout_data;
                nw++;
            end
            if (done) done_cnt++;
            @(negedge clk);
        end
        total++;
        if (nw !== 8) begin
            bad++; $display("FAIL bp_count: got %0d words want 8", nw);
        end
        for (int i = 0; i < 8 && i < nw; i++) begin
            total++;
            if (w[i] !== DW'(i)) begin
                bad++; $display("FAIL bp_word[%0d]: got %0d want %0d", i, w[i], i);
            end
        end
        total++;
        if (done_cnt !== 1) begin
            bad++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt);
        end
    endtask

    task automatic test_wrap;
        int nw = 0;
        int exp_a [4] = '{2046, 2047, 0, 1};
        logic [DW-1:0] w [4];
        dout_ready = 1'b1;
        issue_cmd(2046, 4);
        for (int k = 1; k <= 12; k++) begin
            if (k <= 4) begin
                total++;
                if (ram_address !== AW'(exp_a[k-1])) begin
                    bad++; $display("FAIL wrap_addr k=%0d: got %0d want %0d", k, ram_address, exp_a[k-1]);
                end
            end
            if (dout_valid && dout_ready) begin
                if (nw < 4) w[nw] = dout_data;
                nw++;
            end
            @(negedge clk);
        end
        total++;
        if (nw !== 4) begin
            bad++; $display("FAIL wrap_count: got %0d words want 4", nw);
        end
        for (int i = 0; i < 4 && i < nw; i++) begin
            total++;
            if (w[i] !== DW'(exp_a[i])) begin
                bad++; $display("FAIL wrap_word[%0d]: got %0d want %0d", i, w[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_zero_len;
        int done_cnt = 0, valid_cnt = 0, busy_cnt = 0;
        dout_ready = 1'b1;
        issue_cmd(300, 0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL zero_done: got done=%b busy=%b want 1 0", done, busy);
        end
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (dout_valid) valid_cnt++;
            if (busy) busy_cnt++;
        end
        total++;
        if (done_cnt !== 0 || valid_cnt !== 0 || busy_cnt !== 0) begin
            bad++; $display("FAIL zero_quiet: got done=%0d valid=%0d busy=%0d want 0 0 0", done_cnt, valid_cnt, busy_cnt);
        end
    endtask

    task automatic test_full_len;
        int n = 0, seq_err = 0, miss = 0;
        bit got_done = 0;
        int seen [NW];
        for (int i = 0; i < NW; i++) seen[i] = 0;
        dout_ready = 1'b1;
        issue_cmd(7, NW);
        for (int k = 1; k <= 2200 && !got_done; k++) begin
            if (dout_valid && dout_ready) begin
                if (dout_data !== DW'((7 + n) % NW)) seq_err++;
                seen[dout_data[AW-1:0]]++;
                n++;
            end
            if (done) got_done = 1;
            @(negedge clk);
        end
        for (int i = 0; i < NW; i++) if (seen[i] != 1) miss++;
        total++;
        if (n !== NW) begin
            bad++; $display("FAIL full_count: got %0d words want %0d", n, NW);
        end
        total++;
        if (seq_err !== 0 || miss !== 0) begin
            bad++; $display("FAIL full_seq: got %0d order errors %0d bad addresses want 0 0", seq_err, miss);
        end
        total++;
        if (got_done !== 1'b1) begin
            bad++; $display("FAIL full_done: got done=%b within bound want 1", got_done);
        end
    endtask

    task automatic test_reset_mid_burst;
        int done_cnt = 0, valid_cnt = 0, nw = 0, done2 = 0;
        logic [DW-1:0] w [2];
        dout_ready = 1'b1;
        issue_cmd(0, 16);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({dout_valid, busy, done, cmd_ready} !== 4'b0001 || ram_address !== '0 || dout_data !== '0) begin
            bad++; $display("FAIL midrst_outputs: got v/b/d/r=%b addr=%0d data=%0d want 0001 0 0",
                            {dout_valid, busy, done, cmd_ready}, ram_address, dout_data);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (dout_valid) valid_cnt++;
        end
        total++;
        if (done_cnt !== 0 || valid_cnt !== 0) begin
            bad++; $display("FAIL midrst_discard: got done=%0d valid=%0d want 0 0", done_cnt, valid_cnt);
        end
        issue_cmd(100, 2);
        for (int k = 1; k <= 10; k++) begin
            if (dout_valid && dout_ready) begin
                if (nw < 2) w[nw] = dout_data;
                nw++;
            end
            if (done) done2++;
            @(negedge clk);
        end
        total++;
        if (nw !== 2 || done2 !== 1) begin
            bad++; $display("FAIL midrst_new_cmd: got %0d words %0d done want 2 1", nw, done2);
        end
        for (int i = 0; i < 2 && i < nw; i++) begin
            total++;
            if (w[i] !== DW'(100 + i)) begin
                bad++; $display("FAIL midrst_word[%0d]: got %0d want %0d", i, w[i], 100 + i);
            end
        end
    endtask

`ifdef SPRAM_BURST_READER_LAST_EN
    task automatic test_last;
        int nw = 0;
        logic [2:0] lasts = 3'bxxx;
        dout_ready = 1'b1;
        issue_cmd(10, 3);
        for (int k = 1; k <= 10; k++) begin
            if (dout_valid && dout_ready) begin
                if (nw < 3) lasts[nw] = dout_last;
                nw++;
            end
            @(negedge clk);
        end
        total++;
        if (nw !== 3 || lasts !== 3'b100) begin
            bad++; $display("FAIL last_flag: got %0d words lasts(w2..w0)=%b want 3 100", nw, lasts);
        end
    endtask
`endif

    task automatic test_wren;
        total++;
        if (wr_bad !== 0) begin
            bad++; $display("FAIL ram_write_pins: got %0d nonzero cycles want 0", wr_bad);
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) ram_mem[i] = DW'(i);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_full_len();
        test_reset_mid_burst();
`ifdef SPRAM_BURST_READER_LAST_EN
        test_last();
`endif
        test_wren();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
